// File: rtl/spi_boot_ctrl_pkg.sv
// Shared definitions for the SPI boot sequencer: command bytes, end marker,
// FSM encoding and the layout of the status byte returned at chip-select fall.
package spi_boot_pkg;

  localparam logic [7:0]  CMD_WR   = 8'h02;
  localparam logic [7:0]  CMD_RD   = 8'h01;
  localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;

  localparam int STAT_DONE_BIT = 7;
  localparam int STAT_OVF_BIT  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_BYTE,
    ST_WR_COMMIT,
    ST_RD_ADDR,
    ST_RD_FETCH,
    ST_RD_CAPT,
    ST_IGNORE
  } boot_state_e;

  function automatic logic [7:0] status_byte(input logic done, input logic ovf);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_DONE_BIT] = done;
    s[STAT_OVF_BIT]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/spi_boot_ctrl_if.sv
// Byte-stream (SPI slave side) and IMEM port bundle of the boot sequencer.
// The sequencer uses the master view; the slave/IMEM environment uses slave.
interface spi_boot_ctrl_if #(
  parameter int AW = 9
);

  logic          i_csn;
  logic          i_rx_valid;
  logic [7:0]    i_rx_byte;
  logic [7:0]    o_tx_byte;
  logic          o_tx_load;

  logic          o_mem_we;
  logic          o_mem_re;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [31:0]   i_mem_rdata;

  modport master (
    input  i_csn,
    input  i_rx_valid,
    input  i_rx_byte,
    input  i_mem_rdata,
    output o_tx_byte,
    output o_tx_load,
    output o_mem_we,
    output o_mem_re,
    output o_mem_addr,
    output o_mem_wdata
  );

  modport slave (
    output i_csn,
    output i_rx_valid,
    output i_rx_byte,
    output i_mem_rdata,
    input  o_tx_byte,
    input  o_tx_load,
    input  o_mem_we,
    input  o_mem_re,
    input  o_mem_addr,
    input  o_mem_wdata
  );

endinterface

// File: rtl/spi_boot_ctrl_shifter.sv
// 4-byte LSB-first shift register: bytes enter at the top lane and move down,
// so lane 0 always holds the next byte to serialise and, after four shifts,
// the first byte received.
module boot_word_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [31:0] word_reg;
  logic [31:0] word_next;
  logic [1:0]  cnt_reg;
  logic [1:0]  cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_in;
      if (gi == 3) begin : g_top
        assign lane_in = byte_in;
      end else begin : g_mid
        assign lane_in = word_reg[8*gi+8 +: 8];
      end
      assign word_next[8*gi +: 8] = clear ? 8'h00 :
                                    load  ? load_data[8*gi +: 8] :
                                    shift ? lane_in :
                                            word_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg;
    if (clear || load) begin
      cnt_next = 2'd0;
    end else if (shift) begin
      cnt_next = cnt_reg + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg <= 32'h0;
      cnt_reg  <= 2'd0;
    end else begin
      word_reg <= word_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign word     = word_reg;
  assign byte_out = word_reg[7:0];
  assign last     = (cnt_reg == 2'd3);

endmodule

// File: rtl/spi_boot_ctrl.sv
// Boot command sequencer: decodes SPI bytes into IMEM write/read-back sessions
// while PROG holds the core in reset.
module spi_boot_ctrl
  import spi_boot_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_prog,
  spi_boot_ctrl_if.master      bus,
  output logic                 o_cpu_rstn,
  output logic                 o_boot_done,
  output logic                 o_overflow,
  output logic [AW:0]          o_word_count
);

  boot_state_e state_reg;
  boot_state_e state_next;
  logic [AW:0] ptr_reg;
  logic [AW:0] ptr_next;
  logic        done_reg;
  logic        done_next;
  logic        ovf_reg;
  logic        ovf_next;
  logic [7:0]  tx_byte_reg;
  logic [7:0]  tx_byte_next;
  logic        tx_load_reg;
  logic        tx_load_next;
  logic        csn_q_reg;
  logic        cpu_rstn_reg;

  logic        csn_fall;
  logic        csn_rise;
  logic        mem_we;
  logic        mem_re;

  logic        sh_clear;
  logic        sh_load;
  logic        sh_shift;
  logic [31:0] sh_word;
  logic [7:0]  sh_byte_out;
  logic        sh_last;

  boot_word_shifter u_shifter (
    .clk       (i_clk),
    .rst_n     (i_rstn),
    .clear     (sh_clear),
    .load      (sh_load),
    .load_data (bus.i_mem_rdata),
    .shift     (sh_shift),
    .byte_in   (bus.i_rx_byte),
    .word      (sh_word),
    .byte_out  (sh_byte_out),
    .last      (sh_last)
  );

  // csn_q idles high so a chip select held low across reset release is seen as a fresh frame
  assign csn_fall = csn_q_reg & ~bus.i_csn;
  assign csn_rise = ~csn_q_reg & bus.i_csn;

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    done_next    = done_reg;
    ovf_next     = ovf_reg;
    tx_byte_next = tx_byte_reg;
    tx_load_next = 1'b0;
    sh_clear     = 1'b0;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;

    // Deselect (or leaving PROG) abandons any partial word/address; a byte
    // arriving in the same cycle as the deselect is dropped with it.
    if (!i_prog || csn_rise) begin
      state_next = ST_IDLE;
      sh_clear   = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (csn_fall) begin
            tx_byte_next = status_byte(done_reg, ovf_reg);
            tx_load_next = 1'b1;
            state_next   = ST_CMD;
          end
        end

        ST_CMD: begin
          if (bus.i_rx_valid) begin
            tx_byte_next = 8'h00;
            tx_load_next = 1'b1;
            if (bus.i_rx_byte == CMD_WR) begin
              ptr_next   = '0;
              done_next  = 1'b0;
              ovf_next   = 1'b0;
              sh_clear   = 1'b1;
              state_next = ST_WR_BYTE;
            end else if (bus.i_rx_byte == CMD_RD) begin
              sh_clear   = 1'b1;
              state_next = ST_RD_ADDR;
            end else begin
              state_next = ST_IGNORE;
            end
          end
        end

        ST_WR_BYTE: begin
          if (bus.i_rx_valid) begin
            tx_byte_next = 8'h00;
            tx_load_next = 1'b1;
            sh_shift     = 1'b1;
            if (sh_last) begin
              state_next = ST_WR_COMMIT;
            end
          end
        end

        ST_WR_COMMIT: begin
          if (sh_word == END_WORD) begin
            done_next  = 1'b1;
            state_next = ST_IGNORE;
          end else if (!ptr_reg[AW]) begin
            mem_we     = 1'b1;
            ptr_next   = ptr_reg + (AW+1)'(1);
            state_next = ST_WR_BYTE;
          end else begin
            ovf_next   = 1'b1;
            state_next = ST_WR_BYTE;
          end
        end

        // The shifter serialises the previously fetched word out of lane 0
        // while the incoming address bytes fill it from the top.
        ST_RD_ADDR: begin
          if (bus.i_rx_valid) begin
            tx_byte_next = sh_byte_out;
            tx_load_next = 1'b1;
            sh_shift     = 1'b1;
            if (sh_last) begin
              state_next = ST_RD_FETCH;
            end
          end
        end

        ST_RD_FETCH: begin
          mem_re     = 1'b1;
          state_next = ST_RD_CAPT;
        end

        ST_RD_CAPT: begin
          sh_load    = 1'b1;
          state_next = ST_RD_ADDR;
        end

        ST_IGNORE: begin
          if (bus.i_rx_valid) begin
            tx_byte_next = 8'h00;
            tx_load_next = 1'b1;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      tx_byte_reg  <= 8'h00;
      tx_load_reg  <= 1'b0;
      csn_q_reg    <= 1'b1;
      cpu_rstn_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      done_reg     <= done_next;
      ovf_reg      <= ovf_next;
      tx_byte_reg  <= tx_byte_next;
      tx_load_reg  <= tx_load_next;
      csn_q_reg    <= bus.i_csn;
      cpu_rstn_reg <= ~i_prog;
    end
  end

  // Byte address bits [1:0] and everything above the IMEM range are dropped
  assign bus.o_mem_addr  = (state_reg == ST_RD_FETCH) ? sh_word[AW+1:2] : ptr_reg[AW-1:0];
  assign bus.o_mem_wdata = sh_word;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_re    = mem_re;
  assign bus.o_tx_byte   = tx_byte_reg;
  assign bus.o_tx_load   = tx_load_reg;

  assign o_cpu_rstn   = cpu_rstn_reg;
  assign o_boot_done  = done_reg;
  assign o_overflow   = ovf_reg;
  assign o_word_count = ptr_reg;

endmodule

// File: tb/tb_spi_boot_ctrl.sv
// Self-checking bench for spi_boot_ctrl: drives SPI byte sessions, models IMEM,
// and compares tx bytes / memory strobes with a list-based reference model.
module tb_spi_boot_ctrl;

  localparam int AW  = 9;
  localparam int GAP = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          prog;
  logic          cpu_rstn;
  logic          boot_done;
  logic          overflow;
  logic [AW:0]   word_count;

  spi_boot_ctrl_if #(.AW(AW)) bus ();

  spi_boot_ctrl #(.AW(AW)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_prog       (prog),
    .bus          (bus),
    .o_cpu_rstn   (cpu_rstn),
    .o_boot_done  (boot_done),
    .o_overflow   (overflow),
    .o_word_count (word_count)
  );

  always #10 clk = ~clk;

  // IMEM with registered read
  logic [31:0] imem [512];
  always @(posedge clk) begin
    if (bus.o_mem_we) imem[bus.o_mem_addr] <= bus.o_mem_wdata;
    if (bus.o_mem_re) bus.i_mem_rdata <= imem[bus.o_mem_addr];
  end

  logic [7:0]  tx_log [$];
  logic [40:0] wr_log [$];
  int          re_cnt = 0;

  always @(negedge clk) begin
    if (bus.o_tx_load === 1'b1) tx_log.push_back(bus.o_tx_byte);
    if (bus.o_mem_we === 1'b1)  wr_log.push_back({bus.o_mem_addr, bus.o_mem_wdata});
    if (bus.o_mem_re === 1'b1)  re_cnt++;
  end

  int          checks = 0;
  int          errors = 0;
  int          re_base;
  logic [7:0]  stim_q [$];
  logic [7:0]  exp_tx [$];
  logic [40:0] exp_wr [$];
  logic [31:0] word_q [$];
  logic [31:0] addr_q [$];
  logic [31:0] ref_mem [512];
  logic        m_done = 1'b0;
  logic        m_ovf  = 1'b0;
  int          m_ptr  = 0;

  // ---------------- reference model ----------------
  task automatic model_write();
    logic [AW-1:0] a;
    stim_q.delete(); exp_tx.delete(); exp_wr.delete();
    exp_tx.push_back({m_done, m_ovf, 6'b0});
    stim_q.push_back(8'h02);
    exp_tx.push_back(8'h00);
    m_done = 1'b0; m_ovf = 1'b0; m_ptr = 0;
    foreach (word_q[i]) begin
      for (int k = 0; k < 4; k++) begin
        stim_q.push_back(word_q[i][8*k +: 8]);
        exp_tx.push_back(8'h00);
      end
      if (word_q[i] == 32'hFFFF_FFFF) begin
        m_done = 1'b1;
        break;
      end
      if (m_ptr < 512) begin
        a = m_ptr[AW-1:0];
        exp_wr.push_back({a, word_q[i]});
        ref_mem[m_ptr] = word_q[i];
        m_ptr++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic model_read();
    logic [31:0] prev;
    stim_q.delete(); exp_tx.delete(); exp_wr.delete();
    exp_tx.push_back({m_done, m_ovf, 6'b0});
    stim_q.push_back(8'h01);
    exp_tx.push_back(8'h00);
    prev = 32'h0;
    foreach (addr_q[i]) begin
      for (int k = 0; k < 4; k++) begin
        stim_q.push_back(addr_q[i][8*k +: 8]);
        exp_tx.push_back(prev[8*k +: 8]);
      end
      prev = ref_mem[addr_q[i][10:2]];
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_byte  = b;
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic do_session(input string nm);
    tx_log.delete(); wr_log.delete(); re_base = re_cnt;
    @(posedge clk); #1;
    bus.i_csn = 1'b0;
    repeat (4) @(posedge clk);
    foreach (stim_q[i]) send_byte(stim_q[i]);
    @(posedge clk); #1;
    bus.i_csn = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("session %s: bytes=%0d tx=%0d writes=%0d reads=%0d", nm, stim_q.size(),
             tx_log.size(), wr_log.size(), re_cnt - re_base);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; prog = 1'b1;
    bus.i_csn = 1'b1; bus.i_rx_valid = 1'b0; bus.i_rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_rstn, boot_done, overflow, bus.o_tx_load, bus.o_mem_we, bus.o_mem_re} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000", {cpu_rstn, boot_done, overflow,
               bus.o_tx_load, bus.o_mem_we, bus.o_mem_re});
    end
    checks++;
    if (word_count !== '0 || bus.o_tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_values count %0d tx %02h exp 0 00", word_count, bus.o_tx_byte);
    end
    checks++;
    if (bus.o_mem_addr !== '0 || bus.o_mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem_bus addr %0d wdata %08h exp 0 00000000", bus.o_mem_addr, bus.o_mem_wdata);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_rstn !== 1'b0) begin
      errors++;
      $display("FAIL reset_prog_hold cpu_rstn got %b exp 0", cpu_rstn);
    end
    m_done = 1'b0; m_ovf = 1'b0; m_ptr = 0;
  endtask

  task automatic test_write(input string nm);
    logic [AW:0] exp_wc;
    model_write();
    do_session(nm);
    checks++;
    if (tx_log.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL %s tx_count got %0d exp %0d", nm, tx_log.size(), exp_tx.size());
    end
    foreach (exp_tx[i]) if (i < tx_log.size()) begin
      checks++;
      if (tx_log[i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL %s tx[%0d] got %02h exp %02h", nm, i, tx_log[i], exp_tx[i]);
      end
    end
    checks++;
    if (wr_log.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL %s write_count got %0d exp %0d", nm, wr_log.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < wr_log.size()) begin
      checks++;
      if (wr_log[i] !== exp_wr[i]) begin
        errors++;
        $display("FAIL %s write[%0d] got addr %0d data %08h exp addr %0d data %08h", nm, i,
                 wr_log[i][40:32], wr_log[i][31:0], exp_wr[i][40:32], exp_wr[i][31:0]);
      end
    end
    exp_wc = m_ptr[AW:0];
    checks++;
    if (boot_done !== m_done || overflow !== m_ovf || word_count !== exp_wc
        || re_cnt != re_base) begin
      errors++;
      $display("FAIL %s status got done %b ovf %b count %0d reads %0d exp %b %b %0d 0", nm,
               boot_done, overflow, word_count, re_cnt - re_base, m_done, m_ovf, exp_wc);
    end
  endtask

  task automatic test_read(input string nm);
    model_read();
    do_session(nm);
    checks++;
    if (tx_log.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL %s tx_count got %0d exp %0d", nm, tx_log.size(), exp_tx.size());
    end
    foreach (exp_tx[i]) if (i < tx_log.size()) begin
      checks++;
      if (tx_log[i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL %s tx[%0d] got %02h exp %02h", nm, i, tx_log[i], exp_tx[i]);
      end
    end
    checks++;
    if (wr_log.size() != 0 || (re_cnt - re_base) != addr_q.size()) begin
      errors++;
      $display("FAIL %s strobes got writes %0d reads %0d exp 0 %0d", nm, wr_log.size(),
               re_cnt - re_base, addr_q.size());
    end
  endtask

  task automatic test_random_rw(input int rounds);
    logic [31:0] w;
    logic [31:0] a;
    int          n;
    int          idx;
    for (int r = 0; r < rounds; r++) begin
      word_q.delete();
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        word_q.push_back(w);
      end
      if ($urandom_range(0, 1) == 1) word_q.push_back(32'hFFFF_FFFF);
      test_write("rand_write");
      addr_q.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        a = $urandom;
        idx = $urandom_range(0, m_ptr - 1);
        a[10:2] = idx[8:0];
        addr_q.push_back(a);
      end
      test_read("rand_read");
    end
  endtask

  task automatic test_abort();
    int n;
    stim_q.delete(); exp_tx.delete();
    exp_tx.push_back({m_done, m_ovf, 6'b0});
    stim_q.push_back(8'h02);
    exp_tx.push_back(8'h00);
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      stim_q.push_back(8'($urandom));
      exp_tx.push_back(8'h00);
    end
    m_done = 1'b0; m_ovf = 1'b0; m_ptr = 0;
    do_session("abort");
    checks++;
    if (tx_log.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL abort tx_count got %0d exp %0d", tx_log.size(), exp_tx.size());
    end
    checks++;
    if (wr_log.size() != 0 || word_count !== '0 || boot_done !== 1'b0) begin
      errors++;
      $display("FAIL abort state got writes %0d count %0d done %b exp 0 0 0", wr_log.size(),
               word_count, boot_done);
    end
    word_q.delete();
    word_q.push_back(32'h0BAD_CAFE);
    test_write("abort_next");
  endtask

  task automatic test_unknown();
    logic [7:0] cmd;
    stim_q.delete(); exp_tx.delete();
    do cmd = 8'($urandom); while (cmd == 8'h01 || cmd == 8'h02);
    exp_tx.push_back({m_done, m_ovf, 6'b0});
    stim_q.push_back(cmd);
    exp_tx.push_back(8'h00);
    for (int i = 0; i < 8; i++) begin
      stim_q.push_back(8'($urandom));
      exp_tx.push_back(8'h00);
    end
    do_session("unknown");
    checks++;
    if (tx_log.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL unknown tx_count got %0d exp %0d", tx_log.size(), exp_tx.size());
    end
    foreach (exp_tx[i]) if (i < tx_log.size()) begin
      checks++;
      if (tx_log[i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL unknown tx[%0d] got %02h exp %02h", i, tx_log[i], exp_tx[i]);
      end
    end
    checks++;
    if (wr_log.size() != 0 || re_cnt != re_base) begin
      errors++;
      $display("FAIL unknown strobes got writes %0d reads %0d exp 0 0", wr_log.size(), re_cnt - re_base);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    logic [7:0]  st;
    word_q.delete();
    for (int i = 0; i < 513; i++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h1;
      word_q.push_back(w);
    end
    word_q.push_back(32'hFFFF_FFFF);
    test_write("overflow");
    stim_q.delete();
    stim_q.push_back(8'h55);
    do_session("overflow_status");
    st = (tx_log.size() > 0) ? tx_log[0] : 8'hxx;
    checks++;
    if (st !== 8'hC0) begin
      errors++;
      $display("FAIL overflow_status got %02h exp c0", st);
    end
  endtask

  task automatic test_reset_midword();
    tx_log.delete(); wr_log.delete();
    @(posedge clk); #1;
    bus.i_csn = 1'b0;
    repeat (4) @(posedge clk);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_byte  = 8'hCC;
    rstn = 1'b0;
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rstn !== 1'b0 || bus.o_tx_load !== 1'b0 || bus.o_mem_we !== 1'b0
        || word_count !== '0 || boot_done !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midword_reset got cpu_rstn %b load %b we %b count %0d done %b ovf %b exp all 0",
               cpu_rstn, bus.o_tx_load, bus.o_mem_we, word_count, boot_done, overflow);
    end
    repeat (3) @(posedge clk); #1;
    bus.i_csn = 1'b1;
    repeat (3) @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_log.size() != 0) begin
      errors++;
      $display("FAIL midword_partial_write got %0d writes exp 0", wr_log.size());
    end
    m_done = 1'b0; m_ovf = 1'b0; m_ptr = 0;
    word_q.delete();
    word_q.push_back(32'h1234_5678);
    test_write("after_reset");
  endtask

  task automatic test_prog();
    logic [AW:0] wc_before;
    wc_before = word_count;
    @(posedge clk); #1;
    prog = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rstn !== 1'b0) begin
      errors++;
      $display("FAIL prog_release_early cpu_rstn got %b exp 0", cpu_rstn);
    end
    @(negedge clk);
    checks++;
    if (cpu_rstn !== 1'b1) begin
      errors++;
      $display("FAIL prog_release cpu_rstn got %b exp 1", cpu_rstn);
    end
    stim_q.delete();
    stim_q.push_back(8'h02);
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
    do_session("prog_low");
    checks++;
    if (tx_log.size() != 0 || wr_log.size() != 0 || re_cnt != re_base || word_count !== wc_before) begin
      errors++;
      $display("FAIL prog_low_activity got tx %0d writes %0d reads %0d count %0d exp 0 0 0 %0d",
               tx_log.size(), wr_log.size(), re_cnt - re_base, word_count, wc_before);
    end
    @(posedge clk); #1;
    prog = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_rstn !== 1'b0) begin
      errors++;
      $display("FAIL prog_reassert cpu_rstn got %b exp 0", cpu_rstn);
    end
  endtask

  initial begin
    test_reset();

    word_q.delete();
    word_q.push_back(32'h0000_0013);
    word_q.push_back(32'h00A0_0093);
    word_q.push_back(32'hFFFF_FFFF);
    test_write("write_fixed");

    addr_q.delete();
    addr_q.push_back(32'd0);
    addr_q.push_back(32'd4);
    addr_q.push_back(32'd8);
    test_read("read_fixed");

    test_random_rw(3);
    test_abort();
    test_unknown();
    test_overflow();
    test_reset_midword();
    test_prog();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
